// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit burst memory, four beats per line.
// Optional CLA_ALIGN_ADDR_EN: force the outbound burst address to line alignment.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64,
    parameter int n_beats = s_line / s_burst
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [s_line-1:0]  line_i,
    output logic [s_line-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [s_burst-1:0] burst_i,
    output logic [s_burst-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int cw = $clog2(n_beats);
    localparam int ab = $clog2(s_line / 8);
    localparam logic [cw-1:0] last = cw'(n_beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t state, next;

    logic [cw-1:0]     cnt;
    logic [s_line-1:0] wline;
    logic [31:0]       addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (write_i) begin
                    next = WRITE;
                end else if (read_i) begin
                    next = READ;
                end
            end
            READ: begin
                if (resp_i && cnt == last) begin
                    next = DONE;
                end
            end
            WRITE: begin
                if (resp_i && cnt == last) begin
                    next = DONE;
                end
            end
            DONE: next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Beat counter, latched write line/address, and read line assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            wline  <= '0;
            addr   <= '0;
            line_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_i) begin
                        wline <= line_i;
                        addr  <= address_i;
                        cnt   <= '0;
                    end else if (read_i) begin
                        addr <= address_i;
                        cnt  <= '0;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line_o[s_burst*cnt +: s_burst] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        unique case (state)
            READ:  read_o = 1'b1;
            WRITE: begin
                write_o = 1'b1;
                burst_o = wline[s_burst*cnt +: s_burst];
            end
            DONE:  resp_o = 1'b1;
            default: ;
        endcase
    end

`ifdef CLA_ALIGN_ADDR_EN
    assign address_o = addr & ~32'((64'd1 << ab) - 64'd1);
`else
    assign address_o = addr;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed table-driven bench for cacheline_adaptor plus async-reset sequence.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [255:0] line_i = '0;
    logic [255:0] line_o;
    logic [31:0]  address_i = '0;
    logic         read_i = 1'b0;
    logic         write_i = 1'b0;
    logic         resp_o;
    logic [63:0]  burst_i = '0;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        logic         rsp;
        logic [63:0]  bi;
        logic [255:0] li;
        logic [31:0]  ai;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [63:0]  e_bo;
        logic [31:0]  e_ao;
        logic [255:0] e_lo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic rsp,
        input logic [63:0] bi, input logic [255:0] li, input logic [31:0] ai,
        input logic e_rd, input logic e_wr, input logic e_resp,
        input logic [63:0] e_bo, input logic [31:0] e_ao,
        input logic [255:0] e_lo
    );
        vec_t v;
        v.rd = rd; v.wr = wr; v.rsp = rsp;
        v.bi = bi; v.li = li; v.ai = ai;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
        v.e_bo = e_bo; v.e_ao = e_ao; v.e_lo = e_lo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    localparam logic [63:0] B1 = {16{4'h1}};
    localparam logic [63:0] B2 = {16{4'h2}};
    localparam logic [63:0] B3 = {16{4'h3}};
    localparam logic [63:0] B4 = {16{4'h4}};
    localparam logic [63:0] B5 = {16{4'h5}};
    localparam logic [63:0] B6 = {16{4'h6}};
    localparam logic [63:0] B7 = {16{4'h7}};
    localparam logic [63:0] B8 = {16{4'h8}};
    localparam logic [63:0] B9 = {16{4'h9}};
    localparam logic [63:0] WA = {16{4'hA}};
    localparam logic [63:0] WB = {16{4'hB}};
    localparam logic [63:0] WC = {16{4'hC}};
    localparam logic [63:0] WD = {16{4'hD}};
    localparam logic [63:0] WE = {16{4'hE}};
    localparam logic [63:0] X0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] X1 = 64'h1032_5476_98BA_DCFE;
    localparam logic [63:0] X2 = 64'hF0F0_0F0F_A5A5_5A5A;
    localparam logic [63:0] X3 = 64'h8000_0000_0000_0001;
    localparam logic [255:0] LR = {B4, B3, B2, B1};
    localparam logic [255:0] LW = {WD, WC, WB, WA};
    localparam logic [255:0] LX = {X3, X2, X1, X0};
    localparam logic [255:0] Z = '0;
`ifdef CLA_ALIGN_ADDR_EN
    localparam logic [31:0] AL = 32'h0000_0040;
`else
    localparam logic [31:0] AL = 32'h0000_0047;
`endif

    initial begin
        int resp_cnt;
        int waited;
        bit seen;

        // Asynchronous reset state
        #2;
        chk("rst_read_o", {255'b0, read_o}, 256'd0);
        chk("rst_write_o", {255'b0, write_o}, 256'd0);
        chk("rst_resp_o", {255'b0, resp_o}, 256'd0);
        chk("rst_burst_o", {192'b0, burst_o}, 256'd0);
        chk("rst_address_o", {224'b0, address_o}, 256'd0);
        chk("rst_line_o", line_o, 256'd0);
        @(negedge clk);
        rst = 1'b1;

        // Read 0x40, back-to-back beats; read_i still held in DONE cycle
        tbl.push_back(mk(1,0,0,0,0,32'h40, 1,0,0,0,32'h40,Z));
        tbl.push_back(mk(1,0,1,B1,0,32'h40, 1,0,0,0,32'h40,{192'b0,B1}));
        tbl.push_back(mk(1,0,1,B2,0,32'h40, 1,0,0,0,32'h40,{128'b0,B2,B1}));
        tbl.push_back(mk(1,0,1,B3,0,32'h40, 1,0,0,0,32'h40,{64'b0,B3,B2,B1}));
        tbl.push_back(mk(1,0,1,B4,0,32'h40, 0,0,1,0,32'h40,LR));
        tbl.push_back(mk(1,0,0,0,0,32'h40, 0,0,0,0,32'h40,LR));
        // Stray resp_i while idle
        tbl.push_back(mk(0,0,1,WE,0,32'h999, 0,0,0,0,32'h40,LR));
        tbl.push_back(mk(0,0,1,WE,0,32'h999, 0,0,0,0,32'h40,LR));
        // Write 0x1FE0 with gapped accepts 1,0,1,0,0,1,1
        tbl.push_back(mk(0,1,0,0,LW,32'h1FE0, 0,1,0,WA,32'h1FE0,LR));
        tbl.push_back(mk(0,1,1,0,LW,32'h1FE0, 0,1,0,WB,32'h1FE0,LR));
        tbl.push_back(mk(0,1,0,0,LW,32'h1FE0, 0,1,0,WB,32'h1FE0,LR));
        tbl.push_back(mk(0,1,1,0,LW,32'h1FE0, 0,1,0,WC,32'h1FE0,LR));
        tbl.push_back(mk(0,1,0,0,LW,32'h1FE0, 0,1,0,WC,32'h1FE0,LR));
        tbl.push_back(mk(0,1,0,0,LW,32'h1FE0, 0,1,0,WC,32'h1FE0,LR));
        tbl.push_back(mk(0,1,1,0,LW,32'h1FE0, 0,1,0,WD,32'h1FE0,LR));
        tbl.push_back(mk(0,1,1,0,LW,32'h1FE0, 0,0,1,0,32'h1FE0,LR));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,32'h1FE0,LR));
        // Read and write together: write wins
        tbl.push_back(mk(1,1,0,0,LX,32'h200, 0,1,0,X0,32'h200,LR));
        tbl.push_back(mk(1,1,1,B9,LX,32'h200, 0,1,0,X1,32'h200,LR));
        tbl.push_back(mk(1,1,1,B9,LX,32'h200, 0,1,0,X2,32'h200,LR));
        tbl.push_back(mk(1,1,1,B9,LX,32'h200, 0,1,0,X3,32'h200,LR));
        tbl.push_back(mk(1,1,1,B9,LX,32'h200, 0,0,1,0,32'h200,LR));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,32'h200,LR));
        // Unaligned read 0x47 overwrites line_o beat by beat
        tbl.push_back(mk(1,0,0,0,0,32'h47, 1,0,0,0,AL,LR));
        tbl.push_back(mk(1,0,1,B5,0,32'h47, 1,0,0,0,AL,{B4,B3,B2,B5}));
        tbl.push_back(mk(1,0,0,B9,0,32'h47, 1,0,0,0,AL,{B4,B3,B2,B5}));
        tbl.push_back(mk(1,0,1,B6,0,32'h47, 1,0,0,0,AL,{B4,B3,B6,B5}));
        tbl.push_back(mk(1,0,1,B7,0,32'h47, 1,0,0,0,AL,{B4,B7,B6,B5}));
        tbl.push_back(mk(1,0,1,B8,0,32'h47, 0,0,1,0,AL,{B8,B7,B6,B5}));
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0,AL,{B8,B7,B6,B5}));

        foreach (tbl[i]) begin
            @(negedge clk);
            read_i = tbl[i].rd;
            write_i = tbl[i].wr;
            resp_i = tbl[i].rsp;
            burst_i = tbl[i].bi;
            line_i = tbl[i].li;
            address_i = tbl[i].ai;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_read_o", i), {255'b0, read_o}, {255'b0, tbl[i].e_rd});
            chk($sformatf("v%0d_write_o", i), {255'b0, write_o}, {255'b0, tbl[i].e_wr});
            chk($sformatf("v%0d_resp_o", i), {255'b0, resp_o}, {255'b0, tbl[i].e_resp});
            chk($sformatf("v%0d_burst_o", i), {192'b0, burst_o}, {192'b0, tbl[i].e_bo});
            chk($sformatf("v%0d_address_o", i), {224'b0, address_o}, {224'b0, tbl[i].e_ao});
            chk($sformatf("v%0d_line_o", i), line_o, tbl[i].e_lo);
        end

        // Reset during a write after two accepted beats
        @(negedge clk);
        write_i = 1'b1;
        line_i = LW;
        address_i = 32'h300;
        resp_i = 1'b0;
        @(negedge clk);
        resp_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_burst_o", {192'b0, burst_o}, {192'b0, WC});
        #2;
        rst = 1'b0;
        #1;
        chk("abort_read_o", {255'b0, read_o}, 256'd0);
        chk("abort_write_o", {255'b0, write_o}, 256'd0);
        chk("abort_resp_o", {255'b0, resp_o}, 256'd0);
        chk("abort_burst_o", {192'b0, burst_o}, 256'd0);
        chk("abort_address_o", {224'b0, address_o}, 256'd0);
        chk("abort_line_o", line_o, 256'd0);
        write_i = 1'b0;
        resp_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort_resp_o", {255'b0, resp_o}, 256'd0);

        // Clean read of 0x100 after the abort, minimum latency
        read_i = 1'b1;
        address_i = 32'h100;
        @(negedge clk);
        chk("clean_read_o", {255'b0, read_o}, 256'd1);
        chk("clean_address_o", {224'b0, address_o}, 256'h100);
        resp_cnt = 0;
        seen = 1'b0;
        waited = 0;
        for (int k = 0; k < 4; k++) begin
            resp_i = 1'b1;
            burst_i = 64'(k + 9) * 64'h0101_0101_0101_0101;
            @(negedge clk);
            waited++;
            if (resp_o) begin
                resp_cnt++;
            end
        end
        resp_i = 1'b0;
        while (!seen && waited < 10) begin
            if (resp_o) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        chk("clean_resp_latency", 256'(waited), 256'd4);
        chk("clean_resp_early", 256'(resp_cnt), 256'd1);
        chk("clean_line_o", line_o,
            {64'h0C0C_0C0C_0C0C_0C0C, 64'h0B0B_0B0B_0B0B_0B0B,
             64'h0A0A_0A0A_0A0A_0A0A, 64'h0909_0909_0909_0909});
        read_i = 1'b0;
        @(negedge clk);
        chk("clean_resp_single", {255'b0, resp_o}, 256'd0);
        chk("clean_idle_read_o", {255'b0, read_o}, 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

Bridges the cache's 256-bit line interface (`pmem_*` side of the cache) to a 64-bit burst physical memory. Sits directly downstream of the cache. It converts one line read into four 64-bit inbound beats, and one line write into four 64-bit outbound beats. It returns a single-cycle `resp_o` to the cache when the whole line has transferred.

## Interface
Parameters:
- `s_line`, 256, cache line width in bits
- `s_burst`, 64, memory beat width in bits
- `n_beats`, `s_line/s_burst` (4), beats per line

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `line_i`  in  256  line to write; connects to cache `pmem_wdata`
- `line_o`  out  256  assembled read line; connects to cache `pmem_rdata`
- `address_i`  in  32  line address; connects to cache `pmem_address`
- `read_i`  in  1  line read request; held until `resp_o`
- `write_i`  in  1  line write request; held until `resp_o`
- `resp_o`  out  1  one-cycle completion pulse; connects to cache `pmem_resp`
- `burst_i`  in  64  inbound beat from memory
- `burst_o`  out  64  outbound beat to memory
- `address_o`  out  32  latched burst address
- `read_o`  out  1  burst read request
- `write_o`  out  1  burst write request
- `resp_i`  in  1  memory beat strobe: data valid (read) or beat accepted (write)

## Operation
- FSM states: IDLE, READ, WRITE, DONE. There is a 2-bit beat counter `cnt`.
- **IDLE**
  - On `write_i`: latch `line_i` and `address_i`, clear `cnt`, go to WRITE.
  - Else on `read_i`: latch `address_i`, clear `cnt`, go to READ.
  - If both are high, write wins.
- **READ**
  - `read_o`=1.
  - On each `resp_i`, store `burst_i` into `line_o[64*cnt +: 64]` and increment `cnt`.
  - On the beat with `cnt`==3, go to DONE.
- **WRITE**
  - `write_o`=1 and `burst_o` = latched line `[64*cnt +: 64]`.
  - On each `resp_i`, the beat is accepted and `cnt` increments.
  - On the acceptance with `cnt`==3, go to DONE.
- **DONE**
  - `resp_o`=1 for exactly one cycle, then return to IDLE.
  - `read_o` and `write_o` are 0.
- Beat order is ascending: beat 0 carries bits [63:0].
- `cnt` wraps 3→0 and is never read outside READ/WRITE.
- `line_o` holds its last assembled value until the next read overwrites it beat by beat. Writes do not disturb it.
- `read_i`/`write_i` are ignored outside IDLE. `resp_i` is ignored in IDLE and DONE.
- Gaps between beats (`resp_i` low) are allowed. The state and counter hold across a gap.
- `address_o` is stable from entry into READ/WRITE through DONE.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, `cnt`=0, `line_o`=0, `burst_o`=0, `address_o`=0, `read_o`=0, `write_o`=0, `resp_o`=0. Reset mid-burst aborts the transfer; no `resp_o` is issued.
- All outputs are registered, or decoded from registered state and registered line data only. `line_o` and `burst_o` have no combinational path from `burst_i` or `line_i`.
- The request is sampled at edge E. `read_o`/`write_o` go high in cycle E+1.
- Minimum latency:
  - With `resp_i` high on 4 consecutive cycles starting E+1, `resp_o` is high in cycle E+5.
  - `line_o` is complete in that same cycle.
- The cache drops its request the cycle after `resp_o`. The adaptor is back in IDLE in that cycle, so the next request is sampled no earlier than E+6.

## Configuration
- `CLA_ALIGN_ADDR_EN`
  - Defined: `address_o` is the latched address with bits [4:0] forced to 0 (32-byte line aligned).
  - Undefined: `address_o` is the latched `address_i` unchanged.

## Test plan
- Reset during WRITE after 2 accepted beats -> all outputs 0 immediately. A following clean read of 0x0000_0100 completes normally.
- Read 0x0000_0040; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive cycles -> `read_o` high 4 cycles, `address_o`=0x0000_0040, `resp_o` pulses once 5 cycles after request, `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write line {0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA..} to 0x0000_1FE0, with `resp_i` gapped (1,0,1,0,0,1,1) -> `burst_o` sequence AAAA, BBBB, CCCC, DDDD advances only on `resp_i`; `resp_o` pulses the cycle after the 4th accept.
- `read_i` and `write_i` both high -> WRITE path taken, `read_o` stays 0.
- Stray `resp_i` in IDLE -> no state change, `line_o` unchanged, `resp_o` stays 0.
- `CLA_ALIGN_ADDR_EN` defined, read at 0x0000_0047 -> `address_o`=0x0000_0040. Undefined -> 0x0000_0047.
